// File: rtl/wall_follower_fsm.sv
// Wall-following robot Moore controller: debounced head/left sensors, timed reroute turn, rotation watchdog, turn counter.
// Optional state-change trace for simulation is compiled in when WALL_FOLLOW_TRACE_EN is defined.
module wall_follower_fsm #(
    parameter int DEBOUNCE     = 2,
    parameter int ROT_MAX      = 8,
    parameter int RESET_CYCLES = 3,
    parameter int CNT_W        = 4,
    parameter int TURN_W       = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              head,
    input  logic              left,
    output logic              front,
    output logic              rotate,
    output logic              dir,
    output logic              stuck,
    output logic [2:0]        state,
    output logic [TURN_W-1:0] turns
);
    typedef enum logic [2:0] {
        S_IDLE    = 3'b000,
        S_SEARCH  = 3'b001,
        S_FOLLOW  = 3'b010,
        S_ROTATE  = 3'b011,
        S_REROUTE = 3'b100,
        S_STUCK   = 3'b101
    } state_t;

    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE - 1);
    localparam logic [CNT_W-1:0] ROT_LAST = CNT_W'(ROT_MAX - 1);
    localparam logic [CNT_W-1:0] RR_LAST  = CNT_W'(RESET_CYCLES - 1);

    state_t              r_state;
    state_t              w_nxt;
    logic                r_hf, r_lf;
    logic [CNT_W-1:0]    r_hcnt, r_lcnt, r_rot_cnt, r_rr_cnt;
    logic                r_front, r_rotate, r_dir, r_stuck;
    logic [TURN_W-1:0]   r_turns;

    always_comb begin
        w_nxt = S_IDLE;
        if (enable) begin
            case (r_state)
                S_IDLE:    w_nxt = S_SEARCH;
                S_SEARCH:  w_nxt = r_hf ? S_ROTATE : (r_lf ? S_FOLLOW : S_SEARCH);
                S_FOLLOW:  w_nxt = !r_lf ? S_REROUTE : (r_hf ? S_ROTATE : S_FOLLOW);
                S_ROTATE: begin
                    if (!r_hf && r_lf)              w_nxt = S_FOLLOW;
                    else if (r_rot_cnt == ROT_LAST) w_nxt = S_STUCK;
                    else                            w_nxt = S_ROTATE;
                end
                // A wall ahead wins over the reroute timeout.
                S_REROUTE: begin
                    if (r_hf)                      w_nxt = S_ROTATE;
                    else if (r_rr_cnt == RR_LAST)  w_nxt = r_lf ? S_FOLLOW : S_SEARCH;
                    else                           w_nxt = S_REROUTE;
                end
                S_STUCK:   w_nxt = r_hf ? S_STUCK : S_SEARCH;
                default:   w_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_hf      <= 1'b0;
            r_lf      <= 1'b0;
            r_hcnt    <= '0;
            r_lcnt    <= '0;
            r_rot_cnt <= '0;
            r_rr_cnt  <= '0;
            r_front   <= 1'b0;
            r_rotate  <= 1'b0;
            r_dir     <= 1'b0;
            r_stuck   <= 1'b0;
            r_turns   <= '0;
        end else begin
            if (head == r_hf) begin
                r_hcnt <= '0;
            end else if (r_hcnt == DB_LAST) begin
                r_hf   <= head;
                r_hcnt <= '0;
            end else begin
                r_hcnt <= r_hcnt + 1'b1;
            end

            if (left == r_lf) begin
                r_lcnt <= '0;
            end else if (r_lcnt == DB_LAST) begin
                r_lf   <= left;
                r_lcnt <= '0;
            end else begin
                r_lcnt <= r_lcnt + 1'b1;
            end

            r_state   <= w_nxt;
            r_rot_cnt <= (r_state == S_ROTATE && w_nxt == S_ROTATE) ? r_rot_cnt + 1'b1 : '0;
            r_rr_cnt  <= (r_state == S_REROUTE && w_nxt == S_REROUTE) ? r_rr_cnt + 1'b1 : '0;
            if (w_nxt == S_ROTATE && r_state != S_ROTATE)
                r_turns <= r_turns + 1'b1;

            // Outputs are decoded from the next state so they stay aligned with r_state.
            r_front  <= (w_nxt == S_SEARCH) || (w_nxt == S_FOLLOW);
            r_rotate <= (w_nxt == S_ROTATE) || (w_nxt == S_REROUTE);
            r_dir    <= (w_nxt == S_REROUTE);
            r_stuck  <= (w_nxt == S_STUCK);
        end
    end

    assign front  = r_front;
    assign rotate = r_rotate;
    assign dir    = r_dir;
    assign stuck  = r_stuck;
    assign state  = r_state;
    assign turns  = r_turns;

`ifdef WALL_FOLLOW_TRACE_EN
    state_t w_trace_nxt;
    assign w_trace_nxt = rst_n ? w_nxt : S_IDLE;
    always @(posedge clk) begin
        if (w_trace_nxt != r_state)
            $display("%0t wall_follower_fsm: %s -> %s", $time, r_state.name(), w_trace_nxt.name());
    end
`else
    // Trace disabled: no simulation-only logic in this build.
`endif
endmodule

// File: tb/tb_wall_follower_fsm.sv
// Self-checking bench for wall_follower_fsm: per-scenario stimulus tables, expected state/outputs/turns queued on drive and compared after each edge.
module tb_wall_follower_fsm;
    localparam logic [2:0] ST_IDLE    = 3'b000;
    localparam logic [2:0] ST_SEARCH  = 3'b001;
    localparam logic [2:0] ST_FOLLOW  = 3'b010;
    localparam logic [2:0] ST_ROTATE  = 3'b011;
    localparam logic [2:0] ST_REROUTE = 3'b100;
    localparam logic [2:0] ST_STUCK   = 3'b101;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b1;
    logic       head = 1'b1;
    logic       left = 1'b1;
    logic       front, rotate, dir, stuck;
    logic [2:0] state;
    logic [7:0] turns;

    int          vectors = 0;
    int          miscompares = 0;
    logic [14:0] sb[$];
    logic [2:0]  m_prev = ST_IDLE;
    logic [7:0]  m_turns = 8'd0;

    always #5 clk = ~clk;

    wall_follower_fsm #(
        .DEBOUNCE(2), .ROT_MAX(8), .RESET_CYCLES(3), .CNT_W(4), .TURN_W(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .head(head), .left(left),
        .front(front), .rotate(rotate), .dir(dir), .stuck(stuck),
        .state(state), .turns(turns)
    );

    // Expected {state, front, rotate, dir, stuck, turns} for a given state.
    function automatic logic [14:0] expect_vec(input logic [2:0] s, input logic [7:0] t);
        logic [3:0] o;
        case (s)
            ST_SEARCH, ST_FOLLOW: o = 4'b1000;
            ST_ROTATE:            o = 4'b0100;
            ST_REROUTE:           o = 4'b0110;
            ST_STUCK:             o = 4'b0001;
            default:              o = 4'b0000;
        endcase
        return {s, o, t};
    endfunction

    function automatic logic [14:0] observed();
        return {state, front, rotate, dir, stuck, turns};
    endfunction

    // Stimulus row: {head, left, enable, rst_n, expected state after the edge, repeat count}.
    function automatic logic [10:0] stim(input logic h, input logic l, input logic en,
                                         input logic rn, input logic [2:0] es, input int n);
        return {h, l, en, rn, es, 4'(n)};
    endfunction

    task automatic drive(input logic h, input logic l, input logic en, input logic rn,
                         input logic [2:0] es);
        head = h; left = l; enable = en; rst_n = rn;
        if (!rn)
            m_turns = 8'd0;
        else if (es == ST_ROTATE && m_prev != ST_ROTATE)
            m_turns = m_turns + 8'd1;
        m_prev = es;
        sb.push_back(expect_vec(es, m_turns));
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [10:0] t[$];
        logic [14:0] e, got;
        t = '{stim(1, 1, 1, 0, ST_IDLE, 2), stim(0, 0, 1, 1, ST_SEARCH, 2)};
        foreach (t[i]) begin
            for (int k = 0; k < int'(t[i][3:0]); k++) begin
                drive(t[i][10], t[i][9], t[i][8], t[i][7], t[i][6:4]);
                e = sb.pop_front(); got = observed(); vectors++;
                if (got !== e) begin
                    miscompares++;
                    $display("FAIL reset row %0d rep %0d: got st=%b out=%b turns=%0d, want st=%b out=%b turns=%0d",
                             i, k, got[14:12], got[11:8], got[7:0], e[14:12], e[11:8], e[7:0]);
                end
            end
        end
    endtask

    task automatic test_watchdog();
        logic [10:0] t[$];
        logic [14:0] e, got;
        t = '{stim(1, 0, 1, 1, ST_SEARCH, 2), stim(1, 0, 1, 1, ST_ROTATE, 8),
              stim(1, 0, 1, 1, ST_STUCK, 3), stim(0, 0, 1, 1, ST_STUCK, 2),
              stim(0, 0, 1, 1, ST_SEARCH, 1)};
        foreach (t[i]) begin
            for (int k = 0; k < int'(t[i][3:0]); k++) begin
                drive(t[i][10], t[i][9], t[i][8], t[i][7], t[i][6:4]);
                e = sb.pop_front(); got = observed(); vectors++;
                if (got !== e) begin
                    miscompares++;
                    $display("FAIL watchdog row %0d rep %0d: got st=%b out=%b turns=%0d, want st=%b out=%b turns=%0d",
                             i, k, got[14:12], got[11:8], got[7:0], e[14:12], e[11:8], e[7:0]);
                end
            end
        end
    endtask

    task automatic test_debounce();
        logic [10:0] t[$];
        logic [14:0] e, got;
        t = '{stim(0, 1, 1, 1, ST_SEARCH, 1), stim(0, 0, 1, 1, ST_SEARCH, 2),
              stim(0, 1, 1, 1, ST_SEARCH, 2), stim(0, 1, 1, 1, ST_FOLLOW, 2)};
        foreach (t[i]) begin
            for (int k = 0; k < int'(t[i][3:0]); k++) begin
                drive(t[i][10], t[i][9], t[i][8], t[i][7], t[i][6:4]);
                e = sb.pop_front(); got = observed(); vectors++;
                if (got !== e) begin
                    miscompares++;
                    $display("FAIL debounce row %0d rep %0d: got st=%b out=%b turns=%0d, want st=%b out=%b turns=%0d",
                             i, k, got[14:12], got[11:8], got[7:0], e[14:12], e[11:8], e[7:0]);
                end
            end
        end
    endtask

    task automatic test_reroute();
        logic [10:0] t[$];
        logic [14:0] e, got;
        t = '{stim(0, 0, 1, 1, ST_FOLLOW, 2), stim(0, 0, 1, 1, ST_REROUTE, 3),
              stim(0, 0, 1, 1, ST_SEARCH, 2), stim(0, 1, 1, 1, ST_SEARCH, 2),
              stim(0, 1, 1, 1, ST_FOLLOW, 1),
              stim(0, 0, 1, 1, ST_FOLLOW, 2), stim(0, 0, 1, 1, ST_REROUTE, 1),
              stim(0, 1, 1, 1, ST_REROUTE, 2), stim(0, 1, 1, 1, ST_FOLLOW, 1),
              stim(0, 0, 1, 1, ST_FOLLOW, 2), stim(0, 0, 1, 1, ST_REROUTE, 1),
              stim(1, 0, 1, 1, ST_REROUTE, 2), stim(1, 0, 1, 1, ST_ROTATE, 1)};
        foreach (t[i]) begin
            for (int k = 0; k < int'(t[i][3:0]); k++) begin
                drive(t[i][10], t[i][9], t[i][8], t[i][7], t[i][6:4]);
                e = sb.pop_front(); got = observed(); vectors++;
                if (got !== e) begin
                    miscompares++;
                    $display("FAIL reroute row %0d rep %0d: got st=%b out=%b turns=%0d, want st=%b out=%b turns=%0d",
                             i, k, got[14:12], got[11:8], got[7:0], e[14:12], e[11:8], e[7:0]);
                end
            end
        end
    endtask

    task automatic test_enable();
        logic [10:0] t[$];
        logic [14:0] e, got;
        t = '{stim(1, 0, 1, 1, ST_ROTATE, 1), stim(1, 0, 0, 1, ST_IDLE, 2),
              stim(1, 0, 1, 1, ST_SEARCH, 1), stim(1, 0, 1, 1, ST_ROTATE, 8),
              stim(1, 0, 1, 1, ST_STUCK, 1)};
        foreach (t[i]) begin
            for (int k = 0; k < int'(t[i][3:0]); k++) begin
                drive(t[i][10], t[i][9], t[i][8], t[i][7], t[i][6:4]);
                e = sb.pop_front(); got = observed(); vectors++;
                if (got !== e) begin
                    miscompares++;
                    $display("FAIL enable row %0d rep %0d: got st=%b out=%b turns=%0d, want st=%b out=%b turns=%0d",
                             i, k, got[14:12], got[11:8], got[7:0], e[14:12], e[11:8], e[7:0]);
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [10:0] t[$];
        logic [14:0] e, got;
        t = '{stim(0, 0, 1, 1, ST_STUCK, 2), stim(0, 0, 1, 1, ST_SEARCH, 1),
              stim(0, 1, 1, 1, ST_SEARCH, 2), stim(0, 1, 1, 1, ST_FOLLOW, 1),
              stim(0, 0, 1, 1, ST_FOLLOW, 2), stim(0, 0, 1, 1, ST_REROUTE, 1),
              stim(0, 0, 1, 0, ST_IDLE, 1), stim(0, 0, 1, 1, ST_SEARCH, 2)};
        foreach (t[i]) begin
            for (int k = 0; k < int'(t[i][3:0]); k++) begin
                drive(t[i][10], t[i][9], t[i][8], t[i][7], t[i][6:4]);
                e = sb.pop_front(); got = observed(); vectors++;
                if (got !== e) begin
                    miscompares++;
                    $display("FAIL mid_reset row %0d rep %0d: got st=%b out=%b turns=%0d, want st=%b out=%b turns=%0d",
                             i, k, got[14:12], got[11:8], got[7:0], e[14:12], e[11:8], e[7:0]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_watchdog();
        test_debounce();
        test_reroute();
        test_enable();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
